// File: rtl/inst_mem_boot.sv
// Instruction memory with a byte-stream boot loader and registered fetch.
// Ports: clk, rst, ld_valid/ld_data/ld_last/ld_ready, reload, freeze, address, instruction, inst_valid, fault, loaded_words.
module inst_mem_boot #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] NOP_INSTR   = 32'hE1A00000,
  localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_valid,
  input  logic [7:0]    ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  input  logic          reload,
  input  logic          freeze,
  input  logic [31:0]   address,
  output logic [31:0]   instruction,
  output logic          inst_valid,
  output logic          fault,
  output logic [AW:0]   loaded_words
);

  typedef enum logic {BOOT, RUN} state_t;

  localparam logic [31:0] CAP  = 32'(DEPTH_WORDS) << 2;
  localparam logic [AW-1:0] LASTW = AW'(DEPTH_WORDS - 1);

  state_t         state;
  logic [AW-1:0]  wptr;
  logic [1:0]     bcnt;
  logic [23:0]    asm_q;
  logic [31:0]    mem [DEPTH_WORDS];

  logic           accept;
  logic           wr_en;
  logic [31:0]    wr_word;
  logic [AW-1:0]  idx;
  logic [31:0]    lim;
  logic           bad;

  assign accept = (state == BOOT) && ld_valid;
  assign wr_en  = accept && (bcnt == 2'd3 || ld_last);
  assign idx    = address[AW+1:2];
  assign lim    = 32'(loaded_words) << 2;
  assign bad    = (address[1:0] != 2'b00) ||
                  (address >= lim) ||
                  (address >= CAP);

  // A short final word keeps its bytes at the top; the rest is zero.
  always_comb begin
    wr_word = 32'h0;
    unique case (bcnt)
      2'd0: wr_word = {ld_data, 24'h0};
      2'd1: wr_word = {asm_q[7:0], ld_data, 16'h0};
      2'd2: wr_word = {asm_q[15:0], ld_data, 8'h0};
      2'd3: wr_word = {asm_q, ld_data};
      default: wr_word = 32'h0;
    endcase
  end

  // Array has no reset so old contents survive reset and reload.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wptr] <= wr_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= BOOT;
      wptr         <= '0;
      bcnt         <= 2'd0;
      asm_q        <= 24'h0;
      ld_ready     <= 1'b1;
      instruction  <= NOP_INSTR;
      inst_valid   <= 1'b0;
      fault        <= 1'b0;
      loaded_words <= '0;
    end else begin
      unique case (state)
        BOOT: begin
          if (accept) begin
            if (wr_en) begin
              wptr         <= wptr + 1'b1;
              loaded_words <= {1'b0, wptr} + 1'b1;
              bcnt         <= 2'd0;
              asm_q        <= 24'h0;
              if (ld_last || wptr == LASTW) begin
                state    <= RUN;
                ld_ready <= 1'b0;
              end
            end else begin
              bcnt  <= bcnt + 2'd1;
              asm_q <= {asm_q[15:0], ld_data};
            end
          end
        end
        RUN: begin
          if (reload) begin
            state        <= BOOT;
            wptr         <= '0;
            bcnt         <= 2'd0;
            asm_q        <= 24'h0;
            ld_ready     <= 1'b1;
            instruction  <= NOP_INSTR;
            inst_valid   <= 1'b0;
            fault        <= 1'b0;
            loaded_words <= '0;
          end else if (!freeze) begin
            if (bad) begin
              instruction <= NOP_INSTR;
              inst_valid  <= 1'b0;
              fault       <= 1'b1;
            end else begin
              instruction <= mem[idx];
              inst_valid  <= 1'b1;
              fault       <= 1'b0;
            end
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_mem_boot.sv
// Directed bench for inst_mem_boot with a 4-word memory.
// Covers load, fetch, fault, freeze, reload, full memory and async reset.
module tb_inst_mem_boot;

  localparam logic [31:0] NOP = 32'hE1A00000;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_valid;
  logic [7:0]  ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        reload;
  logic        freeze;
  logic [31:0] address;
  logic [31:0] instruction;
  logic        inst_valid;
  logic        fault;
  logic [2:0]  loaded_words;

  int npass = 0;
  int nfail = 0;

  inst_mem_boot #(
    .DEPTH_WORDS(4),
    .NOP_INSTR(NOP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ld_valid(ld_valid),
    .ld_data(ld_data),
    .ld_last(ld_last),
    .ld_ready(ld_ready),
    .reload(reload),
    .freeze(freeze),
    .address(address),
    .instruction(instruction),
    .inst_valid(inst_valid),
    .fault(fault),
    .loaded_words(loaded_words)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    @(negedge clk);
    ld_valid = 1'b1;
    ld_data  = b;
    ld_last  = last;
    @(posedge clk);
    #1;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a);
    @(negedge clk);
    address = a;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reload();
    @(negedge clk);
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_rdy"}, 32'(ld_ready), 32'd1);
    chk({tag, "_ins"}, instruction, NOP);
    chk({tag, "_vld"}, 32'(inst_valid), 32'd0);
    chk({tag, "_flt"}, 32'(fault), 32'd0);
    chk({tag, "_lw"}, 32'(loaded_words), 32'd0);
  endtask

  initial begin
    rst      = 1'b1;
    ld_valid = 1'b0;
    ld_data  = 8'h00;
    ld_last  = 1'b0;
    reload   = 1'b0;
    freeze   = 1'b0;
    address  = 32'h0;
    #12;
    chk_idle("reset");
    @(negedge clk);
    rst = 1'b0;

    // Program 1: two full words
    send(8'hE3, 0); send(8'hA0, 0);
    send(8'h00, 0); send(8'h14, 0);
    chk("p1_lw1", 32'(loaded_words), 32'd1);
    chk("p1_rdy1", 32'(ld_ready), 32'd1);
    send(8'hE3, 0); send(8'hA0, 0);
    send(8'h1A, 0); send(8'h01, 1);
    chk("p1_rdy0", 32'(ld_ready), 32'd0);
    chk("p1_lw2", 32'(loaded_words), 32'd2);
    fetch(32'd0);
    chk("f0_ins", instruction, 32'hE3A00014);
    chk("f0_vld", 32'(inst_valid), 32'd1);
    chk("f0_flt", 32'(fault), 32'd0);
    fetch(32'd4);
    chk("f4_ins", instruction, 32'hE3A01A01);
    fetch(32'd8);
    chk("f8_flt", 32'(fault), 32'd1);
    chk("f8_vld", 32'(inst_valid), 32'd0);
    chk("f8_ins", instruction, NOP);
    fetch(32'd2);
    chk("mis_flt", 32'(fault), 32'd1);
    chk("mis_vld", 32'(inst_valid), 32'd0);
    fetch(32'd0);
    chk("rec_flt", 32'(fault), 32'd0);
    chk("rec_ins", instruction, 32'hE3A00014);

    // Freeze holds word 0 while address moves to 4
    @(negedge clk);
    freeze  = 1'b1;
    address = 32'd4;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("frz_ins", instruction, 32'hE3A00014);
    end
    @(negedge clk);
    freeze = 1'b0;
    @(posedge clk);
    #1;
    chk("unfrz_ins", instruction, 32'hE3A01A01);

    // Reload with freeze also high: reload wins
    @(negedge clk);
    freeze = 1'b1;
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
    freeze = 1'b0;
    chk_idle("rld1");

    // Program 2: partial final word padded with zeros
    send(8'hAA, 0); send(8'hBB, 0);
    send(8'hCC, 0); send(8'hDD, 0);
    send(8'h11, 0); send(8'h22, 1);
    chk("p2_lw", 32'(loaded_words), 32'd2);
    fetch(32'd4);
    chk("p2_w1", instruction, 32'h11220000);
    fetch(32'd0);
    chk("p2_w0", instruction, 32'hAABBCCDD);
    fetch(32'd8);
    chk("p2_f8_flt", 32'(fault), 32'd1);
    chk("p2_f8_ins", instruction, NOP);
    chk("p2_f8_vld", 32'(inst_valid), 32'd0);

    // Program 3: fill all 4 words, no ld_last
    do_reload();
    for (int i = 0; i < 16; i++) begin
      chk("full_rdy1", 32'(ld_ready), 32'd1);
      send(8'(i), 0);
    end
    for (int i = 16; i < 20; i++) begin
      @(negedge clk);
      ld_valid = 1'b1;
      ld_data  = 8'(i);
      chk("full_rdy0", 32'(ld_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    ld_valid = 1'b0;
    chk("full_lw", 32'(loaded_words), 32'd4);
    fetch(32'd12);
    chk("full_w3", instruction, 32'h0C0D0E0F);
    chk("full_w3v", 32'(inst_valid), 32'd1);
    fetch(32'd16);
    chk("full_cap", 32'(fault), 32'd1);

    // Async reset in the middle of the second word
    do_reload();
    send(8'h50, 0); send(8'h51, 0);
    send(8'h52, 0); send(8'h53, 0);
    send(8'h60, 0); send(8'h61, 0);
    send(8'h62, 0);
    #2;
    rst = 1'b1;
    #1;
    chk_idle("arst");
    @(negedge clk);
    rst = 1'b0;
    send(8'h01, 0); send(8'h02, 0);
    send(8'h03, 0); send(8'h04, 0);
    send(8'h05, 0); send(8'h06, 0);
    send(8'h07, 0); send(8'h08, 1);
    chk("p4_lw", 32'(loaded_words), 32'd2);
    fetch(32'd0);
    chk("p4_w0", instruction, 32'h01020304);
    fetch(32'd4);
    chk("p4_w1", instruction, 32'h05060708);
    chk("p4_vld", 32'(inst_valid), 32'd1);
    do_reload();
    chk("p4_rld_vld", 32'(inst_valid), 32'd0);
    chk("p4_rld_rdy", 32'(ld_ready), 32'd1);

    // Reload in BOOT is ignored: load continues unaffected
    send(8'hDE, 0); send(8'hAD, 0);
    do_reload();
    send(8'hBE, 0); send(8'hEF, 1);
    chk("boot_rld_lw", 32'(loaded_words), 32'd1);
    fetch(32'd0);
    chk("boot_rld_w0", instruction, 32'hDEADBEEF);

    $display("%0d/%0d checks passed", npass, npass + nfail);
    $finish;
  end

endmodule
